ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte to the mouse, such as 0xF4 "enable data reporting" or 0xFF "reset". It runs the full PS/2 host request-to-send sequence over the open-drain clock and data lines and reports completion or failure. The block sits beside the PS/2 mouse receiver on the same PS2Clk/PS2Data pins and runs on the system clock. The top level holds the receiver in reset while `busy` is high, so the receiver's bit counter realigns after each command.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000: system clocks the PS/2 clock line is held low (100 µs at 100 MHz).
- RTS_CYCLES, 100: system clocks data and clock are both held low before the clock is released.
- TIMEOUT_CYCLES, 200000: maximum system clocks allowed between device clock falling edges (2 ms).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low; 0 resets on the next clk edge.
- start  in  1  single-cycle request; sampled only when `busy`=0.
- data  in  8  command byte; latched on an accepted `start`.
- PS2Clk  in  1  raw PS/2 clock pin level.
- PS2Data  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 drives the clock pin low; 0 releases it.
- ps2_data_oe  out  1  1 drives the data pin low; 0 releases it.
- busy  out  1  high from the cycle after an accepted start until the cycle `done` or `err` pulses.
- done  out  1  one-cycle pulse: the byte was sent and the device acknowledged it.
- err  out  1  one-cycle pulse: timeout or missing acknowledge.

## Operation
- PS2Clk and PS2Data each pass through a 2-flop synchronizer. A falling edge (`fe`) is a synchronized previous value of 1 and a current value of 0.
- Frame register, 10 bits, LSB first: {stop=1, parity, data[7:0]}. `parity` = ~^data, which makes the count of ones in data plus parity odd.
- States and transitions:
  - IDLE: both oe=0, busy=0. On `start`=1: latch the frame, clear the counter, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES clocks, set ps2_data_oe=1 (start bit 0) and go to RTS.
  - RTS: both oe=1. After RTS_CYCLES clocks, set ps2_clk_oe=0, bit index=0, clear the timeout counter, go to BITS.
  - BITS: on each `fe`, ps2_data_oe ← ~frame[index], then index+1. After the 10th `fe` (stop bit, data released) go to ACK.
  - ACK: on the next `fe`, sample synchronized data. Data=0 goes to WAIT_IDLE. Data=1 goes to ERR.
  - WAIT_IDLE: wait until synchronized clock=1 and data=1, then go to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
  - ERR: one cycle, `err`=1, both oe=0, then IDLE.
- Timeout counter: cleared on every `fe`; counts in BITS, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES goes to ERR from any of those states.
- `start` while busy: ignored; the latched byte is unchanged.
- Counters are wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES). The bit index is 4 bits.

## Timing
- Reset values (all outputs registered): ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, state=IDLE.
- Reset asserted mid-operation: both lines are released on the next clk edge. No `done` or `err` pulse is produced.
- `start` accepted at edge N: busy=1 and ps2_clk_oe=1 at edge N+1.
- ps2_data_oe=1 exactly INHIBIT_CYCLES clocks after ps2_clk_oe rises.
- ps2_clk_oe falls exactly RTS_CYCLES clocks after that.
- Data update latency: the new ps2_data_oe value is registered 3 clocks after the pin's falling edge (2 sync + 1 detect/register). This is far below the PS/2 half-period of ≥30 µs.
- done/err are exclusive single-cycle pulses. busy falls in the same cycle the pulse is high.
- Earliest new `start` acceptance: the cycle after done/err.

## Test plan
- Send 0xF4 through a device model (10 kHz clock, acks). Required:
  - bits seen at device clock rising edges are 0 (start), 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - data is low at the 11th falling edge;
  - `done` pulses once; `err` stays 0.
- Send 0xFF and 0x00. Required: parity bit = 1 in both cases; `done` pulses.
- Device model never clocks after RTS. Required:
  - `err` pulses TIMEOUT_CYCLES+1 (±1) clocks after ps2_clk_oe falls;
  - both oe=0;
  - busy=0.
- Device model leaves data high on the 11th clock (no ack). Required: `err` pulses; `done` never pulses.
- Send with INHIBIT_CYCLES=10000 and RTS_CYCLES=100. Check:
  - clk_oe high-to-data_oe high = 10000 clocks; data_oe high-to-clk_oe low = 100 clocks;
  - a second `start`=1 with data 0xAA during INHIBIT is ignored and the device receives the first byte.
- Assert reset=0 during the 5th data bit. Required:
  - on the next edge, all outputs = 0;
  - no `done` or `err` pulse;
  - a subsequent 0xF4 send completes with `done`.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte out on device clock edges and checks the acknowledge.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | lines released, waiting for start
// INHIBIT   | clock held low for INHIBIT_CYCLES
// RTS       | clock and data held low (start bit) for RTS_CYCLES
// BITS      | clock released, data bits/parity/stop follow device edges
// ACK       | waiting for device acknowledge on the 11th falling edge
// WAIT_IDLE | waiting for both lines to return high
// DONE      | one-cycle done pulse
// ERR       | one-cycle err pulse (timeout or missing acknowledge)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAX_AB     = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > RTS_CYCLES) ? MAX_AB : RTS_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LOAD     = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE, DONE, ERR
    } state_t;

    state_t        state;
    logic [9:0]    frame;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fe;

    assign fe = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            frame       <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            clk_sync    <= 2'b11;
            data_sync   <= 2'b11;
            clk_prev    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], PS2Clk};
            data_sync <= {data_sync[0], PS2Data};
            clk_prev  <= clk_sync[1];
            done      <= 1'b0;
            err       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        frame      <= {1'b1, ~^data, data};
                        cnt        <= INHIBIT_LOAD;
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == '0) begin
                        ps2_data_oe <= 1'b1;
                        cnt         <= RTS_LOAD;
                        state       <= RTS;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RTS: begin
                    if (cnt == '0) begin
                        ps2_clk_oe <= 1'b0;
                        bit_idx    <= '0;
                        cnt        <= TIMEOUT_LOAD;
                        state      <= BITS;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                BITS: begin
                    if (fe) begin
                        ps2_data_oe <= ~frame[bit_idx];
                        bit_idx     <= bit_idx + 4'd1;
                        cnt         <= TIMEOUT_LOAD;
                        if (bit_idx == 4'd9)
                            state <= ACK;
                    end else if (cnt == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        err         <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ACK: begin
                    // acknowledge is the device pulling data low on this edge
                    if (fe) begin
                        cnt <= TIMEOUT_LOAD;
                        if (data_sync[1]) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            busy        <= 1'b0;
                            err         <= 1'b1;
                            state       <= ERR;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else if (cnt == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        err         <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cnt == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        err         <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
